// File: rtl/thunderbird_pkg.sv
// rtl/thunderbird_pkg.sv - shared lamp patterns, error codes and phase encoding
package thunderbird_pkg;

  localparam logic [2:0] LAMP_OFF = 3'b000;
  localparam logic [2:0] LAMP_A   = 3'b001;
  localparam logic [2:0] LAMP_AB  = 3'b011;
  localparam logic [2:0] LAMP_ABC = 3'b111;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_ILLEGAL = 2'd1,
    ERR_DWELL   = 2'd2,
    ERR_NOEN    = 2'd3
  } err_code_t;

  typedef enum logic [1:0] {
    PH_OFF = 2'd0,
    PH_A   = 2'd1,
    PH_AB  = 2'd2,
    PH_ABC = 2'd3
  } phase_t;

  // Any pattern outside the legal sequence reports as the idle phase.
  function automatic phase_t lamp_phase(input logic [2:0] lamps);
    case (lamps)
      LAMP_A:   lamp_phase = PH_A;
      LAMP_AB:  lamp_phase = PH_AB;
      LAMP_ABC: lamp_phase = PH_ABC;
      default:  lamp_phase = PH_OFF;
    endcase
  endfunction

endpackage

// File: rtl/thunderbird_lamp_monitor_side_checker.sv
// rtl/thunderbird_lamp_monitor_side_checker.sv - one side's sequence/dwell checker
module thunderbird_side_checker
  import thunderbird_pkg::*;
#(
  parameter int STEP_CYCLES = 1,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [2:0]       lamps,
  output logic             err,
  output logic [1:0]       code,
  output logic [1:0]       phase,
  output logic [CNT_W-1:0] count
);

  localparam int D_MAX = STEP_CYCLES + 1;
  localparam int D_W   = $clog2(D_MAX + 1);
  localparam logic [D_W-1:0] STEP_D = D_W'(STEP_CYCLES);
  localparam logic [D_W-1:0] D_SAT  = D_W'(D_MAX);

  logic [2:0]     prev;
  logic           prev_en;
  logic [D_W-1:0] dwell;
  err_code_t      viol;
  logic           complete;
  logic           is_valid;

  always_comb begin
    viol     = ERR_NONE;
    complete = 1'b0;
    is_valid = (lamps == LAMP_OFF) || (lamps == LAMP_A) ||
               (lamps == LAMP_AB)  || (lamps == LAMP_ABC);
    if (!is_valid) begin
      viol = ERR_ILLEGAL;
    end else if (lamps == prev) begin
      if (prev != LAMP_OFF && dwell >= STEP_D) viol = ERR_DWELL;
    end else if (lamps == LAMP_OFF) begin
      // Dropping the enable first makes any return to off a clean abort.
      if (prev_en) begin
        if (prev != LAMP_ABC)     viol = ERR_ILLEGAL;
        else if (dwell == STEP_D) complete = 1'b1;
        else                      viol = ERR_DWELL;
      end
    end else if (prev == LAMP_OFF && lamps == LAMP_A) begin
      if (!prev_en) viol = ERR_NOEN;
    end else if ((prev == LAMP_A && lamps == LAMP_AB) ||
                 (prev == LAMP_AB && lamps == LAMP_ABC)) begin
      if (!prev_en)            viol = ERR_NOEN;
      else if (dwell < STEP_D) viol = ERR_DWELL;
    end else begin
      viol = ERR_ILLEGAL;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev    <= LAMP_OFF;
      prev_en <= 1'b0;
      dwell   <= D_W'(1);
      err     <= 1'b0;
      code    <= ERR_NONE;
      phase   <= PH_OFF;
      count   <= '0;
    end else begin
      prev    <= lamps;
      prev_en <= en;
      phase   <= lamp_phase(lamps);
      if (lamps != prev)     dwell <= D_W'(1);
      else if (dwell != D_SAT) dwell <= dwell + D_W'(1);
      // First violation wins until cleared; clr itself re-arms on this sample.
      if (clr || !err) begin
        err  <= (viol != ERR_NONE);
        code <= viol;
      end
      if (complete && count != {CNT_W{1'b1}}) count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/thunderbird_lamp_monitor.sv
// rtl/thunderbird_lamp_monitor.sv - passive left/right tail-light lamp bus checker
module thunderbird_lamp_monitor
  import thunderbird_pkg::*;
#(
  parameter int STEP_CYCLES = 1,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             left_en,
  input  logic             right_en,
  input  logic [2:0]       lamps_left,
  input  logic [2:0]       lamps_right,
  output logic             err_left,
  output logic             err_right,
  output logic [1:0]       code_left,
  output logic [1:0]       code_right,
  output logic [1:0]       phase_left,
  output logic [1:0]       phase_right,
  output logic [CNT_W-1:0] count_left,
  output logic [CNT_W-1:0] count_right
);

  thunderbird_side_checker #(.STEP_CYCLES(STEP_CYCLES), .CNT_W(CNT_W)) u_left (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .en    (left_en),
    .lamps (lamps_left),
    .err   (err_left),
    .code  (code_left),
    .phase (phase_left),
    .count (count_left)
  );

  thunderbird_side_checker #(.STEP_CYCLES(STEP_CYCLES), .CNT_W(CNT_W)) u_right (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .en    (right_en),
    .lamps (lamps_right),
    .err   (err_right),
    .code  (code_right),
    .phase (phase_right),
    .count (count_right)
  );

endmodule

// File: tb/tb_thunderbird_lamp_monitor.sv
// tb/tb_thunderbird_lamp_monitor.sv - scoreboard bench for thunderbird_lamp_monitor
module tb_thunderbird_lamp_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a = 1'b1, clr_a = 1'b0, len_a = 1'b0, ren_a = 1'b0;
  logic [2:0] ll_a = 3'b000, lr_a = 3'b000;
  logic       el_a, er_a;
  logic [1:0] cl_a, cr_a, pl_a, pr_a, nl_a, nr_a;

  logic       rst_b = 1'b1, clr_b = 1'b0, len_b = 1'b0, ren_b = 1'b0;
  logic [2:0] ll_b = 3'b000, lr_b = 3'b000;
  logic       el_b, er_b;
  logic [1:0] cl_b, cr_b, pl_b, pr_b;
  logic [7:0] nl_b, nr_b;

  thunderbird_lamp_monitor #(.STEP_CYCLES(1), .CNT_W(2)) dut_a (
    .clk(clk), .rst(rst_a), .clr(clr_a), .left_en(len_a), .right_en(ren_a),
    .lamps_left(ll_a), .lamps_right(lr_a), .err_left(el_a), .err_right(er_a),
    .code_left(cl_a), .code_right(cr_a), .phase_left(pl_a), .phase_right(pr_a),
    .count_left(nl_a), .count_right(nr_a)
  );

  thunderbird_lamp_monitor #(.STEP_CYCLES(2), .CNT_W(8)) dut_b (
    .clk(clk), .rst(rst_b), .clr(clr_b), .left_en(len_b), .right_en(ren_b),
    .lamps_left(ll_b), .lamps_right(lr_b), .err_left(el_b), .err_right(er_b),
    .code_left(cl_b), .code_right(cr_b), .phase_left(pl_b), .phase_right(pr_b),
    .count_left(nl_b), .count_right(nr_b)
  );

  typedef struct {
    int         cyc;
    int         idx;
    bit         sel;
    logic [1:0] err;
    logic [3:0] code;
    logic [3:0] ph;
    logic [7:0] cnt_l;
    logic [7:0] cnt_r;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   vid = 0;
  int   checks = 0;
  int   errors = 0;

  // Monitor: outputs settle one cycle after the sample they describe.
  initial forever begin
    exp_t       e;
    logic [1:0] a_err;
    logic [3:0] a_code, a_ph;
    logic [7:0] a_nl, a_nr;
    @(posedge clk);
    cyc++;
    #1;
    while (q.size() > 0 && q[0].cyc == cyc) begin
      e = q.pop_front();
      if (!e.sel) begin
        a_err = {el_a, er_a}; a_code = {cl_a, cr_a}; a_ph = {pl_a, pr_a};
        a_nl = {6'd0, nl_a};  a_nr = {6'd0, nr_a};
      end else begin
        a_err = {el_b, er_b}; a_code = {cl_b, cr_b}; a_ph = {pl_b, pr_b};
        a_nl = nl_b;          a_nr = nr_b;
      end
      checks++;
      if (a_err !== e.err || a_code !== e.code || a_ph !== e.ph ||
          a_nl !== e.cnt_l || a_nr !== e.cnt_r) begin
        errors++;
        $display("FAIL vec%0d dut%0d err=%b/%b code=%h/%h phase=%h/%h cnt_l=%0d/%0d cnt_r=%0d/%0d (got/exp)",
                 e.idx, e.sel, a_err, e.err, a_code, e.code, a_ph, e.ph,
                 a_nl, e.cnt_l, a_nr, e.cnt_r);
      end
    end
  end

  // ee={err_l,err_r}, ec={code_l,code_r}, ep={phase_l,phase_r}
  task automatic vec(input bit sel, input bit r, input bit c, input bit le, input bit re,
                     input logic [2:0] ll, input logic [2:0] lr,
                     input logic [1:0] ee, input logic [3:0] ec, input logic [3:0] ep,
                     input int nl, input int nr);
    exp_t e;
    @(negedge clk);
    if (!sel) begin
      rst_a = r; clr_a = c; len_a = le; ren_a = re; ll_a = ll; lr_a = lr;
    end else begin
      rst_b = r; clr_b = c; len_b = le; ren_b = re; ll_b = ll; lr_b = lr;
    end
    e.cyc = cyc + 1; e.idx = vid++; e.sel = sel;
    e.err = ee; e.code = ec; e.ph = ep;
    e.cnt_l = 8'(nl); e.cnt_r = 8'(nr);
    q.push_back(e);
  endtask

  initial begin
    logic [2:0] seq [4];
    int         cnt;
    seq = '{3'b001, 3'b011, 3'b111, 3'b000};

    // DUT A: STEP_CYCLES=1, CNT_W=2
    vec(0, 1,0,0,0, 3'b000,3'b000, 2'b00,4'h0,4'h0, 0,0);
    vec(0, 0,0,1,0, 3'b000,3'b000, 2'b00,4'h0,4'h0, 0,0);
    vec(0, 0,0,1,0, 3'b001,3'b000, 2'b00,4'h0,4'h4, 0,0);
    vec(0, 0,0,1,0, 3'b011,3'b000, 2'b00,4'h0,4'h8, 0,0);
    vec(0, 0,0,1,0, 3'b111,3'b000, 2'b00,4'h0,4'hC, 0,0);
    vec(0, 0,0,1,0, 3'b000,3'b000, 2'b00,4'h0,4'h0, 1,0);
    // skip 000->011, sticky code through a legal step, clr
    vec(0, 0,0,1,0, 3'b011,3'b000, 2'b10,4'h4,4'h8, 1,0);
    vec(0, 0,0,1,0, 3'b111,3'b000, 2'b10,4'h4,4'hC, 1,0);
    vec(0, 0,1,1,0, 3'b000,3'b000, 2'b00,4'h0,4'h0, 2,0);
    vec(0, 0,0,0,0, 3'b000,3'b000, 2'b00,4'h0,4'h0, 2,0);
    // right side: no enable, then abort after enable drop
    vec(0, 0,0,0,0, 3'b000,3'b001, 2'b01,4'h3,4'h1, 2,0);
    vec(0, 0,1,0,1, 3'b000,3'b000, 2'b00,4'h0,4'h0, 2,0);
    vec(0, 0,0,0,1, 3'b000,3'b001, 2'b00,4'h0,4'h1, 2,0);
    vec(0, 0,0,0,0, 3'b000,3'b011, 2'b00,4'h0,4'h2, 2,0);
    vec(0, 0,0,0,0, 3'b000,3'b000, 2'b00,4'h0,4'h0, 2,0);
    // lockstep x3 then two more left-only sequences: counters saturate at 3
    vec(0, 1,0,0,0, 3'b000,3'b000, 2'b00,4'h0,4'h0, 0,0);
    vec(0, 0,0,1,1, 3'b000,3'b000, 2'b00,4'h0,4'h0, 0,0);
    for (int k = 1; k <= 5; k++) begin
      for (int s = 0; s < 4; s++) begin
        logic [1:0] ph;
        ph  = (s == 3) ? 2'd0 : 2'(s + 1);
        cnt = (s == 3) ? ((k < 3) ? k : 3) : ((k - 1 < 3) ? k - 1 : 3);
        vec(0, 0,0,1,1, seq[s], (k <= 3) ? seq[s] : 3'b000,
            2'b00, 4'h0, {ph, (k <= 3) ? ph : 2'd0}, cnt, cnt);
      end
    end
    vec(0, 0,0,1,1, 3'b000,3'b101, 2'b01,4'h1,4'h0, 3,3);
    vec(0, 0,0,1,1, 3'b001,3'b000, 2'b01,4'h1,4'h4, 3,3);
    vec(0, 1,0,1,1, 3'b011,3'b000, 2'b00,4'h0,4'h0, 0,0);
    vec(0, 0,0,1,0, 3'b011,3'b000, 2'b10,4'h4,4'h8, 0,0);

    // DUT B: STEP_CYCLES=2, CNT_W=8
    vec(1, 1,0,0,0, 3'b000,3'b000, 2'b00,4'h0,4'h0, 0,0);
    vec(1, 0,0,1,0, 3'b000,3'b000, 2'b00,4'h0,4'h0, 0,0);
    vec(1, 0,0,1,0, 3'b001,3'b000, 2'b00,4'h0,4'h4, 0,0);
    vec(1, 0,0,1,0, 3'b011,3'b000, 2'b10,4'h8,4'h8, 0,0);
    vec(1, 0,1,1,0, 3'b000,3'b000, 2'b10,4'h4,4'h0, 0,0);
    vec(1, 0,1,1,0, 3'b000,3'b000, 2'b00,4'h0,4'h0, 0,0);
    vec(1, 0,0,1,0, 3'b001,3'b000, 2'b00,4'h0,4'h4, 0,0);
    vec(1, 0,0,1,0, 3'b001,3'b000, 2'b00,4'h0,4'h4, 0,0);
    vec(1, 0,0,1,0, 3'b011,3'b000, 2'b00,4'h0,4'h8, 0,0);
    vec(1, 0,0,1,0, 3'b011,3'b000, 2'b00,4'h0,4'h8, 0,0);
    vec(1, 0,0,1,0, 3'b111,3'b000, 2'b00,4'h0,4'hC, 0,0);
    vec(1, 0,0,1,0, 3'b111,3'b000, 2'b00,4'h0,4'hC, 0,0);
    vec(1, 0,0,1,0, 3'b000,3'b000, 2'b00,4'h0,4'h0, 1,0);
    vec(1, 0,0,1,0, 3'b001,3'b000, 2'b00,4'h0,4'h4, 1,0);
    vec(1, 0,0,1,0, 3'b001,3'b000, 2'b00,4'h0,4'h4, 1,0);
    vec(1, 0,0,1,0, 3'b001,3'b000, 2'b10,4'h8,4'h4, 1,0);

    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    #3;
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
